// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch line buffer.
// Holds the fill FSM state enum, the instruction width and a log2 helper for the offset width.
package ifetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 1; i < n; i = i * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Purpose: hit-cycle and miss-event counters for the fetch line buffer, saturating at all-ones.
// Latency: counts are visible the cycle after the qualifying event.
// Backpressure: none; the increments are sampled every cycle.
module ifetch_perf_cnt
    import ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_inc,
    input  logic               miss_inc,
    output logic [INSTR_W-1:0] hit_cnt,
    output logic [INSTR_W-1:0] miss_cnt
);

    logic [INSTR_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [INSTR_W-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_inc && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: rtl/ifetch_linebuf.sv
// Purpose: single-line instruction fetch buffer with sequential line refill; IFETCH_PERF_CNT_EN adds hit/miss counters.
// Latency: hits are served combinationally; a miss costs at least LINE_WORDS+1 stall cycles.
// Backpressure: stall holds the upstream PC; the refill waits on mem_ack with mem_req/mem_addr held stable.
module ifetch_linebuf
    import ifetch_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               stall,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int OFF_W = clog2(LINE_WORDS);
    localparam int TAG_W = 32 - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               line_valid_q, line_valid_d;
    logic [OFF_W-1:0]   word_cnt_q, word_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] line_q [LINE_WORDS];
    logic [INSTR_W-1:0] line_d [LINE_WORDS];

    logic [TAG_W-1:0]   pc_tag;
    logic [OFF_W-1:0]   pc_off;
    logic [OFF_W-1:0]   word_cnt_inc;
    logic               hit;
    logic               miss_start;
    logic               unused_pc_bits;

    assign pc_tag         = pc[31:OFF_W+2];
    assign pc_off         = pc[OFF_W+1:2];
    assign word_cnt_inc   = word_cnt_q + 1'b1;
    assign hit            = line_valid_q && (tag_q == pc_tag);
    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        line_valid_d = line_valid_q;
        word_cnt_d   = word_cnt_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        line_d       = line_q;
        instr        = '0;
        instr_valid  = 1'b0;
        stall        = 1'b1;
        miss_start   = 1'b0;

        // Everything is gated on !reset so a reset cycle neither serves nor writes the line.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        instr       = line_q[pc_off];
                        instr_valid = 1'b1;
                        stall       = 1'b0;
                    end
                    if (flush) begin
                        line_valid_d = 1'b0;
                    end else if (!hit) begin
                        tag_d        = pc_tag;
                        word_cnt_d   = '0;
                        line_valid_d = 1'b0;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = {pc_tag, {OFF_W{1'b0}}, 2'b00};
                        miss_start   = 1'b1;
                        state_d      = FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                    if (mem_ack) begin
                        line_d[word_cnt_q] = mem_rdata;
                        word_cnt_d         = word_cnt_inc;
                        mem_addr_d         = {tag_q, word_cnt_inc, 2'b00};
                        if (word_cnt_q == LAST_WORD) begin
                            mem_req_d    = 1'b0;
                            line_valid_d = !flush_pend_q && !flush;
                            flush_pend_d = 1'b0;
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            line_valid_q <= line_valid_d;
            word_cnt_q   <= word_cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef IFETCH_PERF_CNT_EN
    ifetch_perf_cnt u_perf_cnt (
        .clk      (clk),
        .reset    (reset),
        .hit_inc  (instr_valid),
        .miss_inc (miss_start),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = miss_start;
`endif

endmodule

// File: tb/tb_ifetch_linebuf.sv
// Randomized bench for ifetch_linebuf against a line-level reference model, with a few literal pins.
module tb_ifetch_linebuf;

    logic        clk = 1'b0;
    logic        reset, flush, mem_ack;
    logic [31:0] pc, mem_rdata;
    logic [31:0] instr, mem_addr;
    logic        instr_valid, stall, mem_req;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    ifetch_linebuf #(.LINE_WORDS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    // Reference model: resident line, in-flight fill and pending flush, tracked per line.
    bit          m_valid, m_fill, m_fpend;
    logic [27:0] m_tag, m_ftag;
    int          m_got, m_hits, m_misses;
    logic        e_iv, e_stall, e_req;
    logic [31:0] e_instr, e_addr;
    logic        obs_iv, obs_stall, obs_req;
    logic [31:0] obs_instr, obs_addr;
    bit          prev_free;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_outputs();
        e_req  = 1'b0;
        e_addr = 32'h0;
        if (reset) begin
            e_iv = 1'b0; e_stall = 1'b1; e_instr = 32'h0;
        end else if (!m_fill) begin
            e_iv    = m_valid && (m_tag == pc[31:4]);
            e_stall = !e_iv;
            e_instr = e_iv ? mem_fn({pc[31:2], 2'b00}) : 32'h0;
        end else begin
            e_iv = 1'b0; e_stall = 1'b1; e_instr = 32'h0;
            e_req  = 1'b1;
            e_addr = {m_ftag, 2'(m_got), 2'b00};
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_valid = 0; m_fill = 0; m_got = 0; m_fpend = 0; m_hits = 0; m_misses = 0;
        end else if (!m_fill) begin
            if (e_iv) m_hits++;
            if (flush) m_valid = 0;
            else if (!e_iv) begin
                m_fill = 1; m_ftag = pc[31:4]; m_got = 0; m_valid = 0; m_misses++;
            end
        end else begin
            if (e_iv) m_hits++;
            if (flush) m_fpend = 1;
            if (mem_ack) begin
                m_got++;
                if (m_got == 4) begin
                    m_fill = 0; m_tag = m_ftag; m_valid = !m_fpend; m_fpend = 0; m_got = 0;
                end
            end
        end
    endtask

    // Inputs are already set at the falling edge; memory data follows the address the model expects.
    task automatic cycle();
        model_outputs();
        mem_rdata = (mem_ack && m_fill && !reset) ? mem_fn(e_addr) : $urandom;
        #1;
        obs_iv = instr_valid; obs_stall = stall; obs_instr = instr;
        obs_req = mem_req; obs_addr = mem_addr;
        check("instr_valid", {31'h0, instr_valid}, {31'h0, e_iv});
        check("stall", {31'h0, stall}, {31'h0, e_stall});
        check("instr", instr, e_instr);
        if (!reset) check("mem_req", {31'h0, mem_req}, {31'h0, e_req});
        if (!reset && e_req) check("mem_addr", mem_addr, e_addr);
`ifdef IFETCH_PERF_CNT_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
        @(posedge clk);
        model_update();
        prev_free = reset || !e_stall;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [27:0] rtag;
        logic [3:0]  rlow;
        reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; pc = 32'h0; mem_rdata = 32'h0;
        m_valid = 0; m_fill = 0; m_fpend = 0; m_got = 0; m_hits = 0; m_misses = 0;
        m_tag = '0; m_ftag = '0; prev_free = 1;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_iv", {31'h0, obs_iv}, 32'h0);
        check("rst_stall", {31'h0, obs_stall}, 32'h1);
        check("rst_instr", obs_instr, 32'h0);

        // Cold miss at pc 0 with an ack every cycle: five stall cycles.
        reset = 1'b0; mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("pen_stall", {31'h0, obs_stall}, 32'h1);
            if (k > 0) check("fill_addr", obs_addr, 32'(4 * (k - 1)));
        end
        mem_ack = 1'b0;
        cycle();
        check("first_hit_iv", {31'h0, obs_iv}, 32'h1);
        check("first_hit_instr", obs_instr, 32'h11);
        pc = 32'h8;
        cycle();
        check("hit8_instr", obs_instr, 32'h33);
        check("hit8_stall", {31'h0, obs_stall}, 32'h0);

        // Replace with line 0x10, acks on fill cycles 3,7,8,12.
        pc = 32'h10;
        cycle();
        check("miss10_stall", {31'h0, obs_stall}, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            mem_ack = (k == 3 || k == 7 || k == 8 || k == 12);
            cycle();
            if (k == 1) check("gap_addr0", obs_addr, 32'h10);
            if (k == 6) check("gap_addr1", obs_addr, 32'h14);
            if (k == 12) check("gap_addr3", obs_addr, 32'h1C);
            if (k == 12) check("gap_req", {31'h0, obs_req}, 32'h1);
        end
        mem_ack = 1'b0;
        cycle();
        check("hit10_instr", obs_instr, 32'hC0DE_0010);
        pc = 32'h0;
        cycle();
        check("evicted_stall", {31'h0, obs_stall}, 32'h1);

        // Refill line 0, then flush while hitting.
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        mem_ack = 1'b0;
        cycle();
        pc = 32'h4; flush = 1'b1;
        cycle();
        check("flush_hit_iv", {31'h0, obs_iv}, 32'h1);
        check("flush_hit_instr", obs_instr, 32'h22);
        flush = 1'b0;
        cycle();
        check("post_flush_stall", {31'h0, obs_stall}, 32'h1);

        // Flush on the 2nd fill ack: line ends invalid and refetches.
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flush = (k == 1);
            cycle();
        end
        mem_ack = 1'b0; flush = 1'b0;
        cycle();
        check("fpend_stall", {31'h0, obs_stall}, 32'h1);
        cycle();
        check("refetch_req", {31'h0, obs_req}, 32'h1);
        check("refetch_addr", obs_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            mem_ack = ($urandom_range(0, 2) != 0);
            if (prev_free && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: rtag = 28'h0;
                    1: rtag = 28'h1;
                    2: rtag = 28'h2;
                    default: rtag = 28'hFFF_FFFF;
                endcase
                rlow = 4'($urandom);
                pc = {rtag, rlow};
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
